// File: rtl/udp_gmii_rx.sv
// GMII receive front end: hunts preamble/SFD, writes frame body bytes to the RX FIFO, reports length/status.
// Optional FCS check enabled by defining UDP_GMII_RX_FCS_EN.
module udp_gmii_rx #(
    parameter logic [3:0] P_MINPRE = 4'd2,
    parameter logic [6:0] P_MAXLEN = 7'd127
) (
    input  logic       ARSTN,
    input  logic       TCLK,
    input  logic [7:0] RXD,
    input  logic       RXDV,
    input  logic       RXER,
    output logic [7:0] FIFO_WDAT,
    output logic       FIFO_WEN,
    input  logic       FIFO_FULL,
    output logic       RX_START,
    output logic       RX_END,
    output logic [6:0] RX_LEN,
    output logic       RX_ERR
);

    typedef enum logic [2:0] {ST_IDLE, ST_PREA, ST_BDY, ST_DROP, ST_DONE} state_t;

    state_t     state, state_n;
    logic [7:0] rxd_q;
    logic       dv_q, er_q;
    logic [7:0] b;
    logic [3:0] pre_cnt, pre_cnt_n;
    logic [6:0] byte_cnt, byte_cnt_n;
    logic       err_flag, err_flag_n;
    logic       body_flag, body_flag_n;
    logic       wen_n, start_n, end_n;
    logic       fcs_bad;

    // Transmitter swaps nibbles on the pins; undo it here.
    assign b = {rxd_q[3:0], rxd_q[7:4]};

`ifdef UDP_GMII_RX_FCS_EN
    logic [31:0] crc, crc_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs_bad = (crc != 32'hDEBB20E3);
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge TCLK or negedge ARSTN) begin
        if (!ARSTN) begin
            rxd_q     <= '0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            byte_cnt  <= '0;
            err_flag  <= 1'b0;
            body_flag <= 1'b0;
            FIFO_WDAT <= '0;
            FIFO_WEN  <= 1'b0;
            RX_START  <= 1'b0;
            RX_END    <= 1'b0;
            RX_LEN    <= '0;
            RX_ERR    <= 1'b0;
`ifdef UDP_GMII_RX_FCS_EN
            crc       <= '1;
`endif
        end else begin
            rxd_q     <= RXD;
            dv_q      <= RXDV;
            er_q      <= RXER;
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            byte_cnt  <= byte_cnt_n;
            err_flag  <= err_flag_n;
            body_flag <= body_flag_n;
            FIFO_WEN  <= wen_n;
            RX_START  <= start_n;
            RX_END    <= end_n;
            if (wen_n)
                FIFO_WDAT <= b;
            // Status is latched on entry to ST_DONE; no write happens on that transition.
            if (end_n) begin
                RX_LEN <= byte_cnt_n;
                RX_ERR <= err_flag_n | fcs_bad;
            end
`ifdef UDP_GMII_RX_FCS_EN
            crc       <= crc_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        byte_cnt_n  = byte_cnt;
        err_flag_n  = err_flag;
        body_flag_n = body_flag;
        wen_n       = 1'b0;
        start_n     = 1'b0;
`ifdef UDP_GMII_RX_FCS_EN
        crc_n       = crc;
`endif
        case (state)
            ST_IDLE: begin
                pre_cnt_n   = '0;
                byte_cnt_n  = '0;
                err_flag_n  = 1'b0;
                body_flag_n = 1'b0;
`ifdef UDP_GMII_RX_FCS_EN
                crc_n       = '1;
`endif
                if (dv_q) begin
                    if (b == 8'h55) begin
                        state_n   = ST_PREA;
                        pre_cnt_n = 4'd1;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
            end
            ST_PREA: begin
                if (!dv_q || er_q)
                    state_n = ST_DROP;
                else if (b == 8'h55) begin
                    if (pre_cnt != 4'hF)
                        pre_cnt_n = pre_cnt + 4'd1;
                end else if (b == 8'hD5 && pre_cnt >= P_MINPRE)
                    state_n = ST_BDY;
                else
                    state_n = ST_DROP;
            end
            ST_BDY: begin
                // dv fall takes priority over a simultaneous FIFO_FULL.
                if (!dv_q)
                    state_n = ST_DONE;
                else if (er_q || FIFO_FULL || byte_cnt >= P_MAXLEN) begin
                    err_flag_n  = 1'b1;
                    body_flag_n = 1'b1;
                    state_n     = ST_DROP;
                end else begin
                    wen_n      = 1'b1;
                    start_n    = (byte_cnt == '0);
                    byte_cnt_n = byte_cnt + 7'd1;
`ifdef UDP_GMII_RX_FCS_EN
                    crc_n      = crc_byte(crc, b);
`endif
                end
            end
            ST_DROP: begin
                if (!dv_q)
                    state_n = body_flag ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                pre_cnt_n   = '0;
                byte_cnt_n  = '0;
                err_flag_n  = 1'b0;
                body_flag_n = 1'b0;
`ifdef UDP_GMII_RX_FCS_EN
                crc_n       = '1;
`endif
                state_n     = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        end_n = (state_n == ST_DONE);
    end

endmodule
